// File: rtl/mux2x1_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 data mux.
// A hold limit forces handoff while the other side is waiting.
module mux2x1_arbiter #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req1,
   input  logic              req2,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   output logic              grant1,
   output logic              grant2,
   output logic              select,
   output logic [DATA_W-1:0] out,
   output logic              out_valid
);

   typedef enum logic [1:0] {StIdle, StGnt1, StGnt2} state_e;

   localparam logic [7:0] HoldMax = 8'(MAX_HOLD - 1);

   state_e            state_q, state_d;
   logic [7:0]        hold_q, hold_d;
   logic              last_q, last_d;  // 1: requester 2 was served last
   logic              sel_q, sel_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              valid_q, valid_d;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      last_d  = last_q;
      sel_d   = sel_q;
      case (state_q)
         StIdle: begin
            if (req1 && (!req2 || last_q)) state_d = StGnt1;
            else if (req2)                 state_d = StGnt2;
         end
         StGnt1: begin
            if (req2 && (!req1 || hold_q == HoldMax)) state_d = StGnt2;
            else if (!req1)                            state_d = StIdle;
         end
         StGnt2: begin
            if (req1 && (!req2 || hold_q == HoldMax)) state_d = StGnt1;
            else if (!req2)                            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Entry into a grant (including a direct switch) restarts the hold count.
      if (state_d == StGnt1 && state_q != StGnt1) begin
         hold_d = 8'd0;
         last_d = 1'b0;
         sel_d  = 1'b0;
      end else if (state_d == StGnt2 && state_q != StGnt2) begin
         hold_d = 8'd0;
         last_d = 1'b1;
         sel_d  = 1'b1;
      end else if (state_d == state_q && state_q != StIdle && hold_q != HoldMax) begin
         hold_d = hold_q + 8'd1;
      end
   end

   always_comb begin
      out_d   = out_q;
      valid_d = 1'b0;
      if (state_q == StGnt1) begin
         out_d   = in1;
         valid_d = 1'b1;
      end else if (state_q == StGnt2) begin
         out_d   = in2;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         hold_q  <= 8'd0;
         last_q  <= 1'b1;
         sel_q   <= 1'b0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign grant1    = (state_q == StGnt1);
   assign grant2    = (state_q == StGnt2);
   assign select    = sel_q;
   assign out       = out_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Bench for mux2x1_arbiter: directed scenarios plus randomized traffic checked
// against a channel-ownership model.
module tb_mux2x1_arbiter;

   localparam int MaxHold = 4;

   logic       clk = 1'b0;
   logic       rst, req1, req2;
   logic [7:0] in1, in2;
   logic       grant1, grant2, select, out_valid;
   logic [7:0] out;

   int checks = 0;
   int fails  = 0;

   // Model: who owns the channel, for how many visible cycles, who went last.
   int         m_owner, m_held, m_last;
   logic       m_sel, m_valid;
   logic [7:0] m_out;

   mux2x1_arbiter #(.DATA_W(8), .MAX_HOLD(MaxHold)) dut (
      .clk(clk), .rst(rst), .req1(req1), .req2(req2), .in1(in1), .in2(in2),
      .grant1(grant1), .grant2(grant2), .select(select), .out(out),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic model_update();
      int nxt, mine, other;
      if (rst) begin
         m_owner = 0; m_held = 0; m_last = 2; m_sel = 1'b0; m_out = 8'h00; m_valid = 1'b0;
         return;
      end
      m_valid = (m_owner != 0);
      if (m_owner == 1) m_out = in1;
      if (m_owner == 2) m_out = in2;
      if (m_owner == 0) begin
         if (req1 && req2) nxt = (m_last == 1) ? 2 : 1;
         else if (req1)    nxt = 1;
         else if (req2)    nxt = 2;
         else              nxt = 0;
      end else begin
         mine  = (m_owner == 1) ? int'(req1) : int'(req2);
         other = (m_owner == 1) ? int'(req2) : int'(req1);
         if (other != 0 && (mine == 0 || m_held >= MaxHold)) nxt = 3 - m_owner;
         else if (mine == 0) nxt = 0;
         else                nxt = m_owner;
      end
      if (nxt != 0 && nxt != m_owner) begin
         m_held = 1; m_last = nxt; m_sel = (nxt == 2);
      end else if (nxt != 0) begin
         m_held++;
      end
      m_owner = nxt;
   endtask

   function automatic logic [11:0] exp_vec();
      return {m_owner == 1, m_owner == 2, m_sel, m_out, m_valid};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req1 = 1'b0; req2 = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req1 = 1'b1; req2 = 1'b1; in1 = 8'h5A; in2 = 8'hC3;
      tick(); tick();
      checks++;
      if ({grant1, grant2, select, out, out_valid} !== 12'h000) begin
         fails++;
         $display("FAIL reset_state: got %h expected %h",
                  {grant1, grant2, select, out, out_valid}, 12'h000);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({grant1, grant2, out_valid} !== 3'b100) begin
         fails++;
         $display("FAIL reset_first_grant: got %b expected 100", {grant1, grant2, out_valid});
      end
      tick();
      checks++;
      if ({grant1, out_valid, out} !== {2'b11, 8'h5A}) begin
         fails++;
         $display("FAIL reset_first_data: got %h expected %h", {grant1, out_valid, out},
                  {2'b11, 8'h5A});
      end
   endtask

   task automatic test_single();
      do_reset();
      req1 = 1'b1; in1 = 8'hA5;
      for (int c = 1; c <= 5; c++) begin
         tick();
         checks++;
         if (grant1 !== 1'b1 || (c >= 2 && {out_valid, out} !== {1'b1, 8'hA5})) begin
            fails++;
            $display("FAIL single_cycle%0d: got g1=%b v=%b out=%h expected g1=1 v=%b out=%h",
                     c, grant1, out_valid, out, c >= 2, 8'hA5);
         end
      end
      req1 = 1'b0;
      tick();
      checks++;
      if ({grant1, out_valid, out} !== {2'b01, 8'hA5}) begin
         fails++;
         $display("FAIL single_release: got %h expected %h", {grant1, out_valid, out},
                  {2'b01, 8'hA5});
      end
      tick();
      checks++;
      if ({grant1, out_valid} !== 2'b00) begin
         fails++;
         $display("FAIL single_drain: got %b expected 00", {grant1, out_valid});
      end
   endtask

   task automatic test_tie();
      logic [2:0] want [3];
      want[0] = 3'b100; want[1] = 3'b011; want[2] = 3'b100;
      do_reset();
      for (int p = 0; p < 3; p++) begin
         req1 = 1'b1; req2 = 1'b1;
         tick();
         checks++;
         if ({grant1, grant2, select} !== want[p]) begin
            fails++;
            $display("FAIL tie_pulse%0d: got %b expected %b", p, {grant1, grant2, select},
                     want[p]);
         end
         req1 = 1'b0; req2 = 1'b0;
         tick(); tick();
      end
   endtask

   task automatic test_handoff();
      do_reset();
      req1 = 1'b1; in1 = 8'h11; in2 = 8'h22;
      tick(); tick();
      req1 = 1'b0; req2 = 1'b1;
      tick();
      checks++;
      if ({grant1, grant2, select, out} !== {3'b011, 8'h11}) begin
         fails++;
         $display("FAIL handoff_grant: got %h expected %h", {grant1, grant2, select, out},
                  {3'b011, 8'h11});
      end
      tick();
      checks++;
      if ({grant2, out_valid, out} !== {2'b11, 8'h22}) begin
         fails++;
         $display("FAIL handoff_data: got %h expected %h", {grant2, out_valid, out},
                  {2'b11, 8'h22});
      end
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      req1 = 1'b1;
      tick();
      req2 = 1'b1;
      n = 0;
      for (int i = 0; i < 20 && grant1; i++) begin n++; tick(); end
      checks++;
      if (n != MaxHold || grant2 !== 1'b1) begin
         fails++;
         $display("FAIL timeout_g1: got %0d cycles g2=%b expected %0d cycles g2=1",
                  n, grant2, MaxHold);
      end
      n = 0;
      for (int i = 0; i < 20 && grant2; i++) begin n++; tick(); end
      checks++;
      if (n != MaxHold || grant1 !== 1'b1) begin
         fails++;
         $display("FAIL timeout_g2: got %0d cycles g1=%b expected %0d cycles g1=1",
                  n, grant1, MaxHold);
      end
      req2 = 1'b0;
      repeat (10) tick();
      req2 = 1'b1;
      tick();
      checks++;
      if ({grant1, grant2} !== 2'b01) begin
         fails++;
         $display("FAIL timeout_saturated: got %b expected 01", {grant1, grant2});
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req2 = 1'b1; in2 = 8'h3C;
      tick(); tick();
      checks++;
      if ({grant2, select, out} !== {2'b11, 8'h3C}) begin
         fails++;
         $display("FAIL midreset_setup: got %h expected %h", {grant2, select, out},
                  {2'b11, 8'h3C});
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({grant1, grant2, select, out, out_valid} !== 12'h000) begin
         fails++;
         $display("FAIL midreset_clear: got %h expected %h",
                  {grant1, grant2, select, out, out_valid}, 12'h000);
      end
      rst = 1'b0; req1 = 1'b1; req2 = 1'b1;
      tick();
      checks++;
      if ({grant1, grant2} !== 2'b10) begin
         fails++;
         $display("FAIL midreset_tie: got %b expected 10", {grant1, grant2});
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         rst  = ($urandom_range(0, 63) == 0);
         req1 = ($urandom_range(0, 3) != 0);
         req2 = ($urandom_range(0, 3) != 0);
         in1  = 8'($urandom);
         in2  = 8'($urandom);
         tick();
         checks++;
         if ({grant1, grant2, select, out, out_valid} !== exp_vec()) begin
            fails++;
            $display("FAIL random_cycle%0d: got %h expected %h", c,
                     {grant1, grant2, select, out, out_valid}, exp_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b1; req1 = 1'b0; req2 = 1'b0; in1 = 8'h00; in2 = 8'h00;
      test_reset();
      test_single();
      test_tie();
      test_handoff();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mux2x1_arbiter.md
Name: mux2x1_arbiter

Overview:
Two-requester round-robin arbiter that sequences the select line of the 2:1 mux datapath. Two sources share one output channel. The block grants one requester at a time and drives the mux select from its grant state. It registers the selected data word with a valid flag. A hold-time limit forces handoff so that neither requester can starve the other.

Parameters:
DATA_W, 8, width of in1/in2/out data words
MAX_HOLD, 16, max consecutive granted cycles while the other side is requesting (legal range 2..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req1  input  1  requester 1 wants the channel (level, held while using it)
req2  input  1  requester 2 wants the channel
in1  input  DATA_W  data from requester 1
in2  input  DATA_W  data from requester 2
grant1  output  1  registered; requester 1 owns the channel
grant2  output  1  registered; requester 2 owns the channel
select  output  1  registered mux select: 0 = in1, 1 = in2
out  output  DATA_W  registered muxed data
out_valid  output  1  registered; out carries data from a granted requester

Behaviour:
- Reset (rst=1 at a clk edge) sets: state IDLE, grant1=0, grant2=0, select=0, out=0, out_valid=0, hold_cnt=0, last_served=2 (so requester 1 wins the first tie).
- Reset mid-grant drops the grant on the same edge; there is no drain.
- Single clock, all outputs registered; no combinational path from inputs to outputs.
- FSM states:
  - IDLE: no grant.
  - GNT1: grant1=1, select=0.
  - GNT2: grant2=1, select=1.
- grant1 and grant2 are never both 1. select follows the state and holds its last value in IDLE.
- IDLE transitions, evaluated at each edge:
  - req1 only -> GNT1.
  - req2 only -> GNT2.
  - Both -> the requester that is not last_served.
  - Neither -> stay in IDLE.
- Grant latency: 1 cycle from request sampled to grant visible.
- GNTx transitions:
  - reqx=1 and no timeout -> stay.
  - reqx=0 and other req=1 -> go directly to the other grant, with no IDLE bubble.
  - reqx=0 and other req=0 -> IDLE.
  - Timeout: hold_cnt==MAX_HOLD-1 and other req=1 -> forced switch to the other grant, even though reqx=1.
- hold_cnt:
  - Cleared to 0 on every grant entry, including a direct switch.
  - Increments each cycle the state stays in GNTx; saturates at MAX_HOLD-1.
  - Timeout fires only while the other side requests. With no contention, a grant is held indefinitely; the counter stays saturated and switches immediately once the other side requests.
- last_served updates to x on entry to GNTx.
- Datapath:
  - When grant1=1: out <= in1 and out_valid <= 1.
  - When grant2=1: out <= in2 and out_valid <= 1.
  - Otherwise out holds its value and out_valid <= 0.
  - out and out_valid therefore lag grant by 1 cycle. Total request-to-data latency is 2 cycles.
- A requester dropping req loses its grant on the next edge. Data sampled during its final granted cycle still appears on out one cycle later.
- Simultaneous release plus new request from the same side in IDLE: follow the IDLE tie rule.

Test Plan:
1. Reset: assert rst 2 cycles with req1=req2=1 -> grant1=grant2=0, select=0, out=0x00, out_valid=0. After release: grant1=1 next edge, out_valid=1 one edge later.
2. Single requester: req1=1, in1=0xA5, req2=0 for 5 cycles, then req1=0 -> grant1=1 from cycle 1. out=0xA5 with out_valid=1 from cycle 2. Grant drops 1 cycle after req1 falls, and out_valid drops 1 cycle after that.
3. Tie round-robin: from reset, pulse req1=req2=1 for one cycle three times, separated by idle gaps -> grants in the order 1, 2, 1. select follows 0, 1, 0.
4. Handoff without bubble: grant1 active, req2=1, drop req1 -> grant2=1 on the very next edge. No IDLE cycle. out switches from in1 (0x11) to in2 (0x22) one cycle later.
5. Timeout (MAX_HOLD=4): req1 held high, then req2 rises -> grant1 held for exactly 4 cycles, counted from grant entry (or counter saturated), then forced to grant2. After req2 has been granted for 4 cycles with req1 still high, the grant returns to grant1.
6. Reset mid-grant: rst=1 while grant2=1, select=1, out=0x3C -> next edge grant2=0, select=0, out=0x00, out_valid=0. The first tie after reset goes to requester 1.
